vertex_streamer: RTL
====================

# vertex_streamer

Memory-to-pipeline feeder for the nearest-vertex datapath: on a start pulse it reads `N` vertices from a coordinate BRAM and drives them, one coordinate per cycle, into the `distance` unit's per-dimension inputs (`data_valid_in[d]` / `vertex_pos_in[d]`). It is the producing end of that interface. It emits dimension 0 first, then dimension 1, and so on, each as a one-cycle strobe with held data. It also tags each coordinate with its vertex index and flags the end of the stream.

## Interface
- `DIM`, 2, coordinates per vertex; also the width of the valid/data output arrays.
- `ADDR_WIDTH`, 16, BRAM address width; also the width of `num_vertices_in` and `vertex_idx_out`.
- `BRAM_LATENCY`, 2, cycles from address presented to `mem_data_in` valid (≥1).

- `clk_in` input 1: system clock.
- `rst_in` input 1: asynchronous, active-low reset.
- `start_in` input 1: one-cycle start request, sampled in IDLE only.
- `num_vertices_in` input ADDR_WIDTH: vertex count `N`, latched on accepted start.
- `pause_in` input 1: when high, no new address is issued.
- `mem_addr_out` output ADDR_WIDTH: BRAM read address, registered.
- `mem_data_in` input 32: BRAM read data.
- `data_valid_out[DIM]` output 1 each: one-cycle strobe per dimension, at most one high per cycle.
- `vertex_pos_out[DIM]` output 32 each: coordinate for dimension d, held until that dimension's next strobe.
- `vertex_idx_out` output ADDR_WIDTH: vertex index of the coordinate currently strobed.
- `last_out` output 1: high with the final coordinate's strobe.
- `busy_out` output 1: high from the accepted start through the final strobe.
- `done_out` output 1: one-cycle pulse the cycle after the final strobe.

## Operation
- **Memory layout:** coordinate d of vertex v is at address `v*DIM + d`. Addresses wrap modulo 2^ADDR_WIDTH. The total `N*DIM` must not exceed 2^ADDR_WIDTH; behaviour beyond that is undefined.
- **State machine:** IDLE, ISSUE, DRAIN, FINISH.
  - **IDLE:** `start_in` high → latch `N`, clear the address counter and the dimension/vertex counters, go to ISSUE. If `N == 0`, go straight to FINISH instead.
  - **ISSUE:** on each cycle with `pause_in` low, present the next address and advance the counter. The dimension counter runs 0..DIM-1, and the vertex counter increments on its wrap. After address `N*DIM-1` is issued, go to DRAIN.
  - **DRAIN:** wait until every in-flight read has been emitted, then go to FINISH.
  - **FINISH:** one cycle. Pulse `done_out`, then return to IDLE.
- **Tag pipeline:** each issued address carries a tag {issued, dim, vertex, last} through a BRAM_LATENCY-deep shift register. When a tag arrives with `issued` set, register `mem_data_in` into `vertex_pos_out[dim]` and drive `data_valid_out[dim]` high for one cycle. `vertex_idx_out` and `last_out` come from the same tag.
- `pause_in` gates address issue only. Reads already in flight still emit. Pausing therefore produces a gap in the strobes and never drops or duplicates a coordinate.
- `start_in` outside IDLE is ignored.
- Changes to `num_vertices_in` after start have no effect.
- **Reset** (async, `rst_in` low): every output clears immediately, state goes to IDLE, and in-flight tags are discarded. Reset values are:
  - `mem_addr_out`, `vertex_pos_out[*]`, `vertex_idx_out`: 0.
  - `data_valid_out[*]`, `last_out`, `busy_out`, `done_out`: 0.

## Timing
- Start is sampled at the edge ending cycle 0.
- `busy_out` goes high in cycle 1, and `mem_addr_out` = 0 in cycle 1.
- An address presented in cycle t gives data in cycle t+BRAM_LATENCY. The registered strobe appears in cycle t+BRAM_LATENCY+1.
- First strobe therefore appears in cycle BRAM_LATENCY+2 (cycle 4 at default).
- Unpaused throughput is one coordinate per cycle. A full vertex takes DIM consecutive cycles; vertices stream back-to-back with no bubble.
- `busy_out` falls, and `done_out` pulses, in the cycle after the `last_out` strobe.
- With `N == 0`: `done_out` in cycle 1, `busy_out` never high, no strobes.
- **Simultaneous events:**
  - `pause_in` rising in the same cycle an address would issue suppresses that issue.
  - `start_in` in the FINISH cycle is ignored.
- Between strobes, `data_valid_out` is all-zero, and `vertex_pos_out[d]` holds its last value.

## Test plan
- DIM=2, BRAM_LATENCY=2, mem[0]=2938, mem[1]=223, N=1, start in cycle 0:
  - cycle 4: `data_valid_out[0]`, `vertex_pos_out[0]`=2938, idx 0.
  - cycle 5: `data_valid_out[1]`, `vertex_pos_out[1]`=223, `last_out`.
  - cycle 6: `done_out`; `busy_out` low.
  - Outputs hold 2938/223 afterwards.
- N=3, mem[k]=100+k:
  - six consecutive strobes, dims 0,1,0,1,0,1.
  - values 100..105, `vertex_idx_out` 0,0,1,1,2,2.
  - `last_out` only on the sixth.
- N=3, `pause_in` high for 3 cycles starting cycle 2 → exactly 3 idle cycles inserted into the strobe sequence. Six strobes total, values 100..105 in order, `done_out` three cycles later than the unpaused run.
- N=0 start → `done_out` in cycle 1, no `data_valid_out`, `mem_addr_out` stays 0.
- Start with N=4, pulse `start_in` again in cycle 3 with N=1 → ignored; all 8 coordinates emitted.
- `rst_in` low in mid-stream cycle 6:
  - all outputs read 0 within that cycle, no further strobes.
  - After release, a new start with N=1 gives its first strobe 4 cycles after start, with no stale tags.

Source files
------------

// File: rtl/vertex_streamer.sv
// Vertex streamer: reads N vertices from coordinate BRAM and strobes them,
// one coordinate per cycle, into the per-dimension distance-unit inputs.
module vertex_streamer #(
   parameter int DIM          = 2,
   parameter int ADDR_WIDTH   = 16,
   parameter int BRAM_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic [ADDR_WIDTH-1:0] num_vertices_in,
   input  logic                  pause_in,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   input  logic [31:0]           mem_data_in,
   output logic [DIM-1:0]        data_valid_out,
   output logic [31:0]           vertex_pos_out [DIM],
   output logic [ADDR_WIDTH-1:0] vertex_idx_out,
   output logic                  last_out,
   output logic                  busy_out,
   output logic                  done_out
);

   localparam int DW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int LAT = BRAM_LATENCY;

   localparam logic [DW-1:0]         DIM_LAST = DW'(DIM - 1);
   localparam logic [DW-1:0]         DIM_ONE  = DW'(1);
   localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   typedef struct packed {
      logic                  issued;
      logic [DW-1:0]         dim;
      logic [ADDR_WIDTH-1:0] vtx;
      logic                  last;
   } tag_t;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] n_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DW-1:0]         dim_q;
   logic [ADDR_WIDTH-1:0] vtx_q;

   // Entry k describes the address presented k cycles ago; entry LAT
   // lines up with the data currently on mem_data_in.
   tag_t tag_q [LAT+1];

   logic                  start_ok;
   logic                  issue_en;
   logic [ADDR_WIDTH-1:0] cur_n;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DW-1:0]         cur_dim;
   logic [ADDR_WIDTH-1:0] cur_vtx;
   logic                  cur_last;
   logic                  dim_wrap;
   tag_t                  issue_tag;
   tag_t                  out_tag;

   // On the start edge the counters are not yet cleared, so the first
   // issue uses zeroed values and the fresh vertex count directly.
   always_comb begin
      start_ok = (state == S_IDLE) && start_in;
      issue_en = !pause_in &&
                 ((start_ok && (num_vertices_in != '0)) ||
                  (state == S_ISSUE));
      cur_n    = start_ok ? num_vertices_in : n_q;
      cur_addr = start_ok ? '0 : addr_q;
      cur_dim  = start_ok ? '0 : dim_q;
      cur_vtx  = start_ok ? '0 : vtx_q;
      dim_wrap = (cur_dim == DIM_LAST);
      cur_last = dim_wrap && (cur_vtx == (cur_n - ONE));
      issue_tag        = '0;
      issue_tag.issued = issue_en;
      issue_tag.dim    = cur_dim;
      issue_tag.vtx    = cur_vtx;
      issue_tag.last   = cur_last;
      out_tag  = tag_q[LAT];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= S_IDLE;
         n_q   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start_in) begin
                  n_q <= num_vertices_in;
                  if (num_vertices_in == '0)
                     state <= S_FINISH;
                  else if (issue_en && cur_last)
                     state <= S_DRAIN;
                  else
                     state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue_en && cur_last)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (last_out)
                  state <= S_FINISH;
            end
            S_FINISH: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         addr_q       <= '0;
         dim_q        <= '0;
         vtx_q        <= '0;
         mem_addr_out <= '0;
      end else if (issue_en) begin
         mem_addr_out <= cur_addr;
         addr_q       <= cur_addr + ONE;
         dim_q        <= dim_wrap ? '0 : cur_dim + DIM_ONE;
         vtx_q        <= dim_wrap ? cur_vtx + ONE : cur_vtx;
      end else if (start_ok) begin
         mem_addr_out <= '0;
         addr_q       <= '0;
         dim_q        <= '0;
         vtx_q        <= '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int k = 0; k <= LAT; k++)
            tag_q[k] <= '0;
      end else begin
         tag_q[0] <= issue_tag;
         for (int k = 1; k <= LAT; k++)
            tag_q[k] <= tag_q[k-1];
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         data_valid_out <= '0;
         vertex_idx_out <= '0;
         last_out       <= 1'b0;
         for (int d = 0; d < DIM; d++)
            vertex_pos_out[d] <= '0;
      end else begin
         last_out <= out_tag.issued && out_tag.last;
         if (out_tag.issued)
            vertex_idx_out <= out_tag.vtx;
         for (int d = 0; d < DIM; d++) begin
            data_valid_out[d] <= out_tag.issued &&
                                 (out_tag.dim == DW'(d));
            if (out_tag.issued && (out_tag.dim == DW'(d)))
               vertex_pos_out[d] <= mem_data_in;
         end
      end
   end

   assign busy_out = (state == S_ISSUE) || (state == S_DRAIN);
   assign done_out = (state == S_FINISH);

endmodule
